// File: rtl/ramp_sample_framer.sv
// Cuts the ADC stream into one fixed-length, ramp-aligned frame per ramp_start; FRAMER_HEADER_EN adds a frame_ctr header word.
// Latency: one clk from an accepted sample (or from entering capture, for the header) to out_valid.
// Backpressure: none; consumers must take every out_valid word, and a ramp restart mid-frame raises sticky overrun.
`timescale 1ns/1ps
module ramp_sample_framer #(
    parameter int ADC_W         = 12,
    parameter int OUT_W         = 16,
    parameter int SAMPLES       = 1024,
    parameter int SETTLE_CYCLES = 64,
    parameter int CTR_W         = 16
) (
    input  logic              clk,
    input  logic              srst_n,
    input  logic              active,
    input  logic              ramp_start,
    input  logic              adc_valid,
    input  logic [ADC_W-1:0]  adc_data,
    input  logic              clr_overrun,
    output logic              out_valid,
    output logic [OUT_W-1:0]  out_data,
    output logic              out_first,
    output logic              out_last,
    output logic              out_hdr,
    output logic [CTR_W-1:0]  frame_ctr,
    output logic              overrun,
    output logic              busy
);

    localparam int SMP_W = $clog2(SAMPLES);
    localparam int SET_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES + 1) : 1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SETTLE,
        ST_CAPTURE
    } state_t;

    state_t             state_q, state_d;
    logic [SMP_W-1:0]   smp_cnt_q, smp_cnt_d;
    logic [SET_W-1:0]   settle_cnt_q, settle_cnt_d;
    logic               out_valid_q, out_valid_d;
    logic [OUT_W-1:0]   out_data_q, out_data_d;
    logic               out_first_q, out_first_d;
    logic               out_last_q, out_last_d;
    logic               out_hdr_q, out_hdr_d;
    logic [CTR_W-1:0]   frame_ctr_q, frame_ctr_d;
    logic               overrun_q, overrun_d;
    logic               start_frame;
    logic               enter_capture;
    logic [OUT_W-1:0]   sample_ext;

    always_comb begin
        sample_ext              = {OUT_W{adc_data[ADC_W-1]}};
        sample_ext[ADC_W-1:0]   = adc_data;
    end

`ifdef FRAMER_HEADER_EN
    localparam int HDR_W = (OUT_W < CTR_W) ? OUT_W : CTR_W;
    logic [OUT_W-1:0]   hdr_word;

    always_comb begin
        hdr_word              = '0;
        hdr_word[HDR_W-1:0]   = frame_ctr_q[HDR_W-1:0];
    end
`endif

    always_comb begin
        state_d       = state_q;
        smp_cnt_d     = smp_cnt_q;
        settle_cnt_d  = settle_cnt_q;
        out_valid_d   = 1'b0;
        out_data_d    = out_data_q;
        out_first_d   = 1'b0;
        out_last_d    = 1'b0;
        out_hdr_d     = 1'b0;
        frame_ctr_d   = frame_ctr_q;
        overrun_d     = clr_overrun ? 1'b0 : overrun_q;
        start_frame   = 1'b0;
        enter_capture = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (ramp_start && active) begin
                    start_frame = 1'b1;
                end
            end
            ST_SETTLE, ST_CAPTURE: begin
                // Deactivation outranks a restart: a dying ramp never counts as an overrun.
                if (!active) begin
                    state_d   = ST_IDLE;
                    smp_cnt_d = '0;
                end else if (ramp_start) begin
                    overrun_d   = 1'b1;
                    start_frame = 1'b1;
                end else if (state_q == ST_SETTLE) begin
                    if (settle_cnt_q == SET_W'(1)) begin
                        enter_capture = 1'b1;
                    end else begin
                        settle_cnt_d = settle_cnt_q - SET_W'(1);
                    end
                end else if (adc_valid) begin
                    out_valid_d = 1'b1;
                    out_data_d  = sample_ext;
`ifdef FRAMER_HEADER_EN
                    out_first_d = 1'b0;
`else
                    out_first_d = (smp_cnt_q == '0);
`endif
                    if (smp_cnt_q == SMP_W'(SAMPLES - 1)) begin
                        out_last_d  = 1'b1;
                        state_d     = ST_IDLE;
                        smp_cnt_d   = '0;
                        frame_ctr_d = frame_ctr_q + CTR_W'(1);
                    end else begin
                        smp_cnt_d = smp_cnt_q + SMP_W'(1);
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (start_frame) begin
            smp_cnt_d    = '0;
            settle_cnt_d = SET_W'(SETTLE_CYCLES);
            if (SETTLE_CYCLES == 0) begin
                enter_capture = 1'b1;
            end else begin
                state_d = ST_SETTLE;
            end
        end

        if (enter_capture) begin
            state_d = ST_CAPTURE;
`ifdef FRAMER_HEADER_EN
            // Header is registered on the entry edge, so samples can only land from the next edge on.
            out_valid_d = 1'b1;
            out_hdr_d   = 1'b1;
            out_first_d = 1'b1;
            out_data_d  = hdr_word;
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (!srst_n) begin
            state_q      <= ST_IDLE;
            smp_cnt_q    <= '0;
            settle_cnt_q <= '0;
            out_valid_q  <= 1'b0;
            out_data_q   <= '0;
            out_first_q  <= 1'b0;
            out_last_q   <= 1'b0;
            out_hdr_q    <= 1'b0;
            frame_ctr_q  <= '0;
            overrun_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            smp_cnt_q    <= smp_cnt_d;
            settle_cnt_q <= settle_cnt_d;
            out_valid_q  <= out_valid_d;
            out_data_q   <= out_data_d;
            out_first_q  <= out_first_d;
            out_last_q   <= out_last_d;
            out_hdr_q    <= out_hdr_d;
            frame_ctr_q  <= frame_ctr_d;
            overrun_q    <= overrun_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_first = out_first_q;
    assign out_last  = out_last_q;
    assign out_hdr   = out_hdr_q;
    assign frame_ctr = frame_ctr_q;
    assign overrun   = overrun_q;
    assign busy      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_ramp_sample_framer.sv
// Bench for ramp_sample_framer: two instances (settle 4 / 16-bit counter, settle 0 / 2-bit counter) on shared stimulus,
// checked every cycle against a time-window model of the framing rules, plus literal expectations from hand-derived cases.
`timescale 1ns/1ps
module tb_ramp_sample_framer;

    localparam int N = 8;
`ifdef FRAMER_HEADER_EN
    localparam int HDR = 1;
`else
    localparam int HDR = 0;
`endif

    logic        clk = 1'b0;
    logic        srst_n = 1'b0;
    logic        active = 1'b0;
    logic        ramp_start = 1'b0;
    logic        adc_valid = 1'b0;
    logic [11:0] adc_data = '0;
    logic        clr_overrun = 1'b0;

    logic        a_valid, a_first, a_last, a_hdr, a_ovr, a_busy;
    logic [15:0] a_data, a_ctr;
    logic        b_valid, b_first, b_last, b_hdr, b_ovr, b_busy;
    logic [15:0] b_data;
    logic [1:0]  b_ctr;

    always #5 clk = ~clk;

    ramp_sample_framer #(.ADC_W(12), .OUT_W(16), .SAMPLES(N), .SETTLE_CYCLES(4), .CTR_W(16)) dut_a (
        .clk(clk), .srst_n(srst_n), .active(active), .ramp_start(ramp_start),
        .adc_valid(adc_valid), .adc_data(adc_data), .clr_overrun(clr_overrun),
        .out_valid(a_valid), .out_data(a_data), .out_first(a_first), .out_last(a_last),
        .out_hdr(a_hdr), .frame_ctr(a_ctr), .overrun(a_ovr), .busy(a_busy));

    ramp_sample_framer #(.ADC_W(12), .OUT_W(16), .SAMPLES(N), .SETTLE_CYCLES(0), .CTR_W(2)) dut_b (
        .clk(clk), .srst_n(srst_n), .active(active), .ramp_start(ramp_start),
        .adc_valid(adc_valid), .adc_data(adc_data), .clr_overrun(clr_overrun),
        .out_valid(b_valid), .out_data(b_data), .out_first(b_first), .out_last(b_last),
        .out_hdr(b_hdr), .frame_ctr(b_ctr), .overrun(b_ovr), .busy(b_busy));

    int checks = 0;
    int errors = 0;

    // Model state: a frame is "open" from its ramp_start cycle; samples count once the settle window has elapsed.
    int          cyc = 0;
    bit          m_in[2];
    int          m_start[2];
    int          m_nacc[2];
    int          m_frames[2];
    bit          m_ovr[2];
    bit          e_valid[2], e_first[2], e_last[2], e_hdr[2];
    logic [15:0] e_data[2];

    // Observation of DUT word stream for the literal checks.
    int          fw[2], last_fw[2], hdr_seen[2];
    logic [15:0] first_dat[2], hdr_dat[2];
    bit          prev_hdr[2];

    function automatic int settle_of(int k);
        return (k == 0) ? 4 : 0;
    endfunction

    function automatic int ctr_mod(int k);
        return (k == 0) ? 65536 : 4;
    endfunction

    task automatic cmp(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at t=%0t: got %0h, expected %0h", name, $time, act, exp);
        end
    endtask

    task automatic model_step(int k);
        bit set_ovr;
        bit cap_open;
        int v;
        set_ovr    = 1'b0;
        e_valid[k] = 1'b0;
        e_first[k] = 1'b0;
        e_last[k]  = 1'b0;
        e_hdr[k]   = 1'b0;
        if (!srst_n) begin
            m_in[k] = 0; m_nacc[k] = 0; m_frames[k] = 0; m_ovr[k] = 0;
            e_data[k] = 16'h0000;
            return;
        end
        cap_open = m_in[k] && (cyc >= m_start[k] + settle_of(k) + 1);
        if (m_in[k] && !active) begin
            m_in[k] = 0;
        end else if (ramp_start && active) begin
            set_ovr    = m_in[k];
            m_in[k]    = 1;
            m_start[k] = cyc;
            m_nacc[k]  = 0;
        end else if (cap_open && adc_valid) begin
            v = adc_data;
            if (v >= 2048) v = v - 4096;
            e_valid[k] = 1'b1;
            e_data[k]  = v[15:0];
            e_first[k] = (m_nacc[k] == 0) && (HDR == 0);
            if (m_nacc[k] == N - 1) begin
                e_last[k]   = 1'b1;
                m_frames[k] = (m_frames[k] + 1) % ctr_mod(k);
                m_in[k]     = 0;
            end
            m_nacc[k]++;
        end
        if (HDR == 1 && m_in[k] && cyc == m_start[k] + settle_of(k)) begin
            v = m_frames[k];
            e_valid[k] = 1'b1;
            e_hdr[k]   = 1'b1;
            e_first[k] = 1'b1;
            e_data[k]  = v[15:0];
        end
        if (clr_overrun) m_ovr[k] = 0;
        if (set_ovr) m_ovr[k] = 1;
    endtask

    always @(posedge clk) begin
        model_step(0);
        model_step(1);
        cyc++;
    end

    task automatic check_inst(int k, string tag, logic v, logic [15:0] d, logic f, logic l,
                              logic h, logic [15:0] ctr, logic ovr, logic bsy);
        cmp({tag, "_out_valid"}, {31'b0, v}, {31'b0, e_valid[k]});
        cmp({tag, "_out_data"}, {16'b0, d}, {16'b0, e_data[k]});
        cmp({tag, "_out_first"}, {31'b0, f}, {31'b0, e_first[k]});
        cmp({tag, "_out_last"}, {31'b0, l}, {31'b0, e_last[k]});
        cmp({tag, "_out_hdr"}, {31'b0, h}, {31'b0, e_hdr[k]});
        cmp({tag, "_frame_ctr"}, {16'b0, ctr}, m_frames[k]);
        cmp({tag, "_overrun"}, {31'b0, ovr}, {31'b0, m_ovr[k]});
        cmp({tag, "_busy"}, {31'b0, bsy}, {31'b0, m_in[k]});
        if (v === 1'b1) begin
            if (f === 1'b1) fw[k] = 1;
            else fw[k]++;
            if (l === 1'b1) last_fw[k] = fw[k];
            if (h === 1'b1) begin
                hdr_seen[k]++;
                hdr_dat[k] = d;
            end
            if (h !== 1'b1 && (f === 1'b1 || prev_hdr[k])) first_dat[k] = d;
            prev_hdr[k] = (h === 1'b1);
        end
    endtask

    always @(negedge clk) begin
        if (cyc > 0) begin
            check_inst(0, "A", a_valid, a_data, a_first, a_last, a_hdr, a_ctr, a_ovr, a_busy);
            check_inst(1, "B", b_valid, b_data, b_first, b_last, b_hdr, {14'b0, b_ctr}, b_ovr, b_busy);
        end
    end

    task automatic step();
        @(posedge clk);
        #3;
    endtask

    task automatic pulse_start();
        ramp_start = 1'b1;
        step();
        ramp_start = 1'b0;
    endtask

    task automatic wait_words(int k, int target, string name);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 60; i++) begin
            if (fw[k] >= target) begin
                ok = 1'b1;
                break;
            end
            step();
        end
        cmp(name, {31'b0, ok}, 32'd1);
    endtask

    initial begin
        int pre_a;
        int pre_b;
        bit ok;
        for (int k = 0; k < 2; k++) begin
            fw[k] = 0; last_fw[k] = 0; hdr_seen[k] = 0; prev_hdr[k] = 0;
            first_dat[k] = 16'hDEAD; hdr_dat[k] = 16'hDEAD;
        end

        // Reset state
        repeat (3) step();
        srst_n = 1'b1;
        cmp("reset_valid", {31'b0, a_valid}, 0);
        cmp("reset_busy", {31'b0, a_busy}, 0);
        cmp("reset_frame_ctr", {16'b0, a_ctr}, 0);
        cmp("reset_data", {16'b0, a_data}, 0);

        // Basic frame: data 0 arrives in the first cycle after ramp_start
        active = 1'b1;
        adc_valid = 1'b1;
        adc_data = 12'hFFF;
        pulse_start();
        adc_data = 12'h000;
        for (int i = 0; i < 20; i++) begin
            step();
            adc_data = adc_data + 12'h001;
        end
        cmp("basic_first_sample_A", {16'b0, first_dat[0]}, 32'd4);
        cmp("basic_first_sample_B", {16'b0, first_dat[1]}, 32'd0);
        cmp("basic_words_A", last_fw[0], N + HDR);
        cmp("basic_words_B", last_fw[1], N + HDR);
        cmp("basic_frame_ctr_A", {16'b0, a_ctr}, 32'd1);
        cmp("basic_busy_after_A", {31'b0, a_busy}, 32'd0);

        // Sign extension
        adc_data = 12'h800;
        pulse_start();
        step();
        cmp("signext_B", {16'b0, b_data}, 32'h0000F800);
        repeat (20) step();
        cmp("signext_A", {16'b0, a_data}, 32'h0000F800);

        // Overrun: restart after 5 samples
        adc_data = 12'h123;
        pre_a = a_ctr;
        fw[0] = 0;
        pulse_start();
        wait_words(0, 5 + HDR, "overrun_wait_5_samples");
        pulse_start();
        cmp("overrun_set", {31'b0, a_ovr}, 32'd1);
        cmp("overrun_busy", {31'b0, a_busy}, 32'd1);
        ok = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (a_ctr == pre_a + 1) begin
                ok = 1'b1;
                break;
            end
            step();
        end
        cmp("overrun_frame_done", {31'b0, ok}, 32'd1);
        repeat (5) step();
        cmp("overrun_frame_ctr_once", {16'b0, a_ctr}, pre_a + 1);
        cmp("overrun_new_frame_words", last_fw[0], N + HDR);
        clr_overrun = 1'b1;
        step();
        clr_overrun = 1'b0;
        cmp("overrun_cleared", {31'b0, a_ovr}, 32'd0);

        // Deactivation after 3 samples
        pre_a = a_ctr;
        fw[0] = 0;
        pulse_start();
        wait_words(0, 3 + HDR, "deact_wait_3_samples");
        active = 1'b0;
        step();
        active = 1'b1;
        cmp("deact_busy", {31'b0, a_busy}, 32'd0);
        repeat (15) step();
        cmp("deact_frame_ctr", {16'b0, a_ctr}, pre_a);
        cmp("deact_overrun", {31'b0, a_ovr}, 32'd0);
        pulse_start();
        step();
        active = 1'b0;
        ramp_start = 1'b1;
        step();
        active = 1'b1;
        ramp_start = 1'b0;
        cmp("deact_start_same_cycle_busy", {31'b0, a_busy}, 32'd0);
        cmp("deact_start_same_cycle_ovr", {31'b0, a_ovr}, 32'd0);

        // Gapped adc_valid, every third cycle
        pre_b = b_ctr;
        last_fw[0] = 0;
        last_fw[1] = 0;
        for (int i = 0; i < 60; i++) begin
            ramp_start = (i == 0);
            adc_valid = (i % 3 == 0);
            adc_data = 12'($urandom);
            step();
        end
        ramp_start = 1'b0;
        adc_valid = 1'b1;
        cmp("gapped_words_A", last_fw[0], N + HDR);
        cmp("gapped_words_B", last_fw[1], N + HDR);
        cmp("gapped_frame_ctr_B", {30'b0, b_ctr}, (pre_b + 1) % 4);

        // Counter wrap on the 2-bit instance, back-to-back frames
        srst_n = 1'b0;
        repeat (2) step();
        srst_n = 1'b1;
        for (int f = 0; f < 4; f++) begin
            pulse_start();
            for (int i = 0; i < 12; i++) begin
                adc_data = 12'($urandom);
                step();
            end
            if (f == 2) cmp("wrap_three_frames_B", {30'b0, b_ctr}, 32'd3);
        end
        cmp("wrap_four_frames_B", {30'b0, b_ctr}, 32'd0);
        cmp("wrap_four_frames_A", {16'b0, a_ctr}, 32'd4);
        cmp("wrap_no_overrun_A", {31'b0, a_ovr}, 32'd0);

        // Header carries frame_ctr=5 on instance A
        pulse_start();
        repeat (12) step();
        cmp("hdr_prep_frame_ctr", {16'b0, a_ctr}, 32'd5);
        pulse_start();
        repeat (12) step();
`ifdef FRAMER_HEADER_EN
        cmp("hdr_data_A", {16'b0, hdr_dat[0]}, 32'h00000005);
        cmp("hdr_frame_words_A", last_fw[0], 9);
`else
        cmp("hdr_absent_A", hdr_seen[0], 0);
        cmp("hdr_absent_B", hdr_seen[1], 0);
`endif

        // Randomized traffic
        for (int i = 0; i < 4000; i++) begin
            srst_n = ($urandom_range(0, 999) != 0);
            if ($urandom_range(0, 149) == 0) active = ~active;
            ramp_start = ($urandom_range(0, 24) == 0);
            adc_valid = ($urandom_range(0, 3) != 0);
            adc_data = 12'($urandom);
            clr_overrun = ($urandom_range(0, 59) == 0);
            step();
        end
        srst_n = 1'b1;
        ramp_start = 1'b0;
        clr_overrun = 1'b0;
        repeat (3) step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/ramp_sample_framer.md
Name: ramp_sample_framer

Overview:
- Sits directly downstream of the ADF4158 controller, in the clk (40 MHz) domain.
- Consumes the controller's ramp_start pulse and active level. Cuts the continuous ADC sample stream into one fixed-length frame per frequency ramp.
- Frames carry first/last markers and a frame counter, so the FFT/packetiser stage sees ramp-aligned data only.

Parameters:
- ADC_W, 12, ADC sample width.
- OUT_W, 16, output data width. Must be at least ADC_W; samples are sign-extended into it.
- SAMPLES, 1024, samples per frame. Legal range 2..65535.
- SETTLE_CYCLES, 64, clk cycles discarded after ramp_start before capture begins. 0 is legal.
- CTR_W, 16, frame counter width.

Ports:
- clk  in  1  40 MHz system clock.
- srst_n  in  1  synchronous active-low reset.
- active  in  1  synthesizer ramping; level from the controller.
- ramp_start  in  1  one-cycle pulse at the start of each ramp.
- adc_valid  in  1  adc_data valid this cycle.
- adc_data  in  ADC_W  signed ADC sample.
- clr_overrun  in  1  clears sticky overrun.
- out_valid  out  1  output word valid; no backpressure.
- out_data  out  OUT_W  sample, or header word.
- out_first  out  1  first word of frame.
- out_last  out  1  last sample of frame.
- out_hdr  out  1  word is a header; only ever high with FRAMER_HEADER_EN.
- frame_ctr  out  CTR_W  count of completed frames.
- overrun  out  1  sticky: ramp restarted before frame completed.
- busy  out  1  FSM not in IDLE.

Behaviour:
- Reset is srst_n, synchronous, active-low; clock clk. All logic is on posedge clk.
- Reset values:
  - out_valid=0, out_data=0, out_first=0, out_last=0, out_hdr=0.
  - frame_ctr=0, overrun=0, busy=0.
  - FSM=IDLE, sample counter=0, settle counter=0.
- Reset mid-frame drops the frame silently.
- FSM states: IDLE, SETTLE, CAPTURE.
  - IDLE: ramp_start & active -> SETTLE, settle counter loaded with SETTLE_CYCLES. If SETTLE_CYCLES==0, go straight to CAPTURE.
  - SETTLE: counter decrements each cycle. The cycle it reads 1 -> CAPTURE. adc samples are ignored.
  - CAPTURE: each adc_valid accepts one sample.
    - Output latency is 1 cycle: out_valid=1 and out_data=sign-extended adc_data on the following cycle.
    - Sample index 0 asserts out_first (headerless build).
    - Index SAMPLES-1 asserts out_last; the FSM goes to IDLE and frame_ctr increments, wrapping at 2^CTR_W.
- out_valid, out_first, out_last and out_hdr are single-cycle pulses. out_data holds its last value when out_valid=0.
- Abort/restart rules (priority order):
  1. active==0 in SETTLE or CAPTURE -> IDLE. No out_last. frame_ctr and overrun unchanged.
  2. ramp_start in SETTLE or CAPTURE -> overrun<=1. Restart SETTLE with the settle counter reloaded and the sample counter cleared. frame_ctr unchanged, no out_last. A coincident adc_valid sample is discarded.
- active==0 has priority over a coincident ramp_start: go to IDLE, no restart, no overrun.
- ramp_start while active==0 in IDLE is ignored.
- Overrun flag:
  - clr_overrun clears overrun.
  - If a set event and clr_overrun coincide, the set wins.
- busy=1 in SETTLE and CAPTURE.

Optional Feature:
- Macro: FRAMER_HEADER_EN.
- Defined:
  - On the edge entering CAPTURE, register a header word: out_valid=1, out_hdr=1, out_first=1, out_data=frame_ctr, zero-extended/truncated to OUT_W.
  - The header is visible in the first CAPTURE cycle.
  - Samples follow with out_first=0. Sample 0 therefore never carries out_first.
  - A frame totals SAMPLES+1 words.
  - A sample accepted in the first CAPTURE cycle appears the next cycle, so there is no collision with the header.
- Undefined: no header; out_hdr tied 0; out_first marks sample 0.

Test Plan:
- Basic frame, SAMPLES=8, SETTLE_CYCLES=4, adc_valid constant, adc_data ramp 0..: ramp_start -> exactly 8 out_valid words, data 4.. (first 4 cycles settle-dropped relative to capture start). out_first on word 0, out_last on word 7, frame_ctr 0->1, busy low after.
- Sign extension: adc_data=12'h800 in CAPTURE -> out_data=16'hF800 one cycle later.
- Overrun: second ramp_start after 5 of 8 samples -> overrun=1, no out_last, new frame of 8 words with out_first, frame_ctr increments only once. clr_overrun -> overrun=0.
- Deactivation: active drops after 3 samples -> IDLE next cycle, no out_last, frame_ctr unchanged, overrun=0. Same-cycle active=0 and ramp_start -> IDLE, overrun=0.
- SETTLE_CYCLES=0 and gapped adc_valid (every 3rd cycle) -> capture starts the cycle after ramp_start, 8 words on the valid cycles only.
- FRAMER_HEADER_EN with frame_ctr=5: header out_data=16'h0005 with out_hdr=1 and out_first=1, then 8 samples, 9 words total. Counter wrap with CTR_W=2: 4 frames -> frame_ctr returns to 0.
